// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// It sequences a synchronous-read tag RAM and a data RAM that share one index address.
// Fills and write-throughs go to backing memory over a req/ack handshake.
// Valid bits are held here, so reset invalidates the cache without touching RAM contents.
// Optional feature: define CACHE_STATS_EN to build saturating hit/miss counters.
// When CACHE_STATS_EN is undefined, hit_count and miss_count read as 0.

module cache_tag_ctrl #(
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 14,
    parameter int DATA_W = 8,
    localparam int ADDR_W = TAG_W + IDX_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy,
    output logic [IDX_W-1:0]  tr_addr,
    output logic [TAG_W-1:0]  tr_din,
    output logic              tr_we,
    input  logic [TAG_W-1:0]  tr_dout,
    output logic [DATA_W-1:0] dr_din,
    output logic              dr_we,
    input  logic [DATA_W-1:0] dr_dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MEM_RD,
        FILL,
        MEM_WR,
        DONE
    } state_t;

    state_t              state;
    logic [DEPTH-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                hit_q;
    logic                fill_we_q;
    logic                hit_c;

    // The tag RAM answers in COMPARE, so the hit decision is formed from its output directly.
    assign hit_c = valid_q[idx_q] & (tr_dout == tag_q);

    // Both RAMs and the memory port are driven from the latched request.
    assign tr_addr   = idx_q;
    assign tr_din    = tag_q;
    assign mem_addr  = {tag_q, idx_q};
    assign mem_wdata = wdata_q;

    // A write hit must update the data RAM in the same cycle the tag is compared, so that
    // strobe cannot be registered ahead; the fill strobe is registered.
    assign dr_we  = fill_we_q | ((state == COMPARE) & we_q & hit_c);
    assign dr_din = (state == COMPARE) ? wdata_q : rdata_q;

    // Main sequencer: state, latched request, valid bits and registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            valid_q   <= '0;
            tag_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            hit_q     <= 1'b0;
            fill_we_q <= 1'b0;
            tr_we     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        tag_q   <= cpu_addr[ADDR_W-1:IDX_W];
                        idx_q   <= cpu_addr[IDX_W-1:0];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        busy    <= 1'b1;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    hit_q   <= hit_c;
                    rdata_q <= dr_dout;
                    if (we_q) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state   <= MEM_WR;
                    end else if (hit_c) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= 1'b1;
                        cpu_rdata <= dr_dout;
                        state     <= DONE;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        rdata_q   <= mem_rdata;
                        mem_req   <= 1'b0;
                        tr_we     <= 1'b1;
                        fill_we_q <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    tr_we          <= 1'b0;
                    fill_we_q      <= 1'b0;
                    valid_q[idx_q] <= 1'b1;
                    cpu_ready      <= 1'b1;
                    cpu_hit        <= hit_q;
                    cpu_rdata      <= rdata_q;
                    state          <= DONE;
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_hit   <= hit_q;
                        cpu_rdata <= rdata_q;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    cpu_hit   <= 1'b0;
                    cpu_rdata <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Every access passes through COMPARE exactly once, so that is where hits and misses are counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE) begin
            if (hit_c) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: bench for cache_tag_ctrl with RAM and memory models and a result scoreboard.
// Define CACHE_STATS_EN to check the hit/miss counters against the reference model.

module tb_cache_tag_ctrl;

    localparam int IDX_W  = 3;
    localparam int TAG_W  = 14;
    localparam int DATA_W = 8;
    localparam int ADDR_W = TAG_W + IDX_W;

    logic              clock;
    logic              reset_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              busy;
    logic [IDX_W-1:0]  tr_addr;
    logic [TAG_W-1:0]  tr_din;
    logic              tr_we;
    logic [TAG_W-1:0]  tr_dout;
    logic [DATA_W-1:0] dr_din;
    logic              dr_we;
    logic [DATA_W-1:0] dr_dout;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    int checkCount = 0;
    int errorCount = 0;

    cache_tag_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_hit    (cpu_hit),
        .cpu_rdata  (cpu_rdata),
        .busy       (busy),
        .tr_addr    (tr_addr),
        .tr_din     (tr_din),
        .tr_we      (tr_we),
        .tr_dout    (tr_dout),
        .dr_din     (dr_din),
        .dr_we      (dr_we),
        .dr_dout    (dr_dout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronous-read tag and data RAMs, read-before-write, shared address.
    logic [TAG_W-1:0]  tag_ram  [8] = '{default: '0};
    logic [DATA_W-1:0] data_ram [8] = '{default: '0};
    always @(posedge clock) begin
        tr_dout <= tag_ram[tr_addr];
        dr_dout <= data_ram[tr_addr];
        if (tr_we) tag_ram[tr_addr] <= tr_din;
        if (dr_we) data_ram[tr_addr] <= dr_din;
    end

    // Backing memory: written locations remember their data, others return a fixed pattern.
    logic [DATA_W-1:0] mem_model [int];
    function automatic logic [DATA_W-1:0] mem_value(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return a[7:0] ^ 8'hA0;
    endfunction

    // Memory responder: acknowledges after ack_delay wait cycles and checks the request fields.
    int                ack_delay = 0;
    int                wait_cnt  = 0;
    logic [ADDR_W-1:0] exp_mem_addr;
    logic              exp_mem_we;
    logic [DATA_W-1:0] exp_mem_wdata;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (reset_n && mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    checkOutput("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
                    checkOutput("mem_we", 32'(mem_we), 32'(exp_mem_we));
                    if (exp_mem_we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
                    mem_rdata = mem_value(mem_addr);
                    mem_ack   = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Strobe monitors: count RAM writes and memory-request cycles per access.
    int                dr_we_cnt = 0;
    int                tr_we_cnt = 0;
    int                mem_req_cnt = 0;
    logic [DATA_W-1:0] last_dr_din = '0;
    logic [TAG_W-1:0]  last_tr_din = '0;
    logic [IDX_W-1:0]  last_tr_addr = '0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (dr_we) begin
                dr_we_cnt++;
                last_dr_din = dr_din;
            end
            if (tr_we) begin
                tr_we_cnt++;
                last_tr_din  = tr_din;
                last_tr_addr = tr_addr;
            end
            if (mem_req) mem_req_cnt++;
        end
    end

    // Scoreboard: each completion pops the expectation pushed when its request was driven.
    typedef struct {
        logic              is_read;
        logic              hit;
        logic [DATA_W-1:0] rdata;
    } exp_t;
    exp_t sb[$];
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && cpu_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("cpu_hit", 32'(cpu_hit), 32'(e.hit));
                if (e.is_read) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
            end
        end
    end

    // Reference model of cache contents and stats.
    logic              valid_m [8];
    logic [TAG_W-1:0]  tag_m   [8];
    logic [DATA_W-1:0] data_m  [8];
    int                exp_hits = 0;
    int                exp_misses = 0;

    // Drive one CPU access, update the model, push the expectation and check side effects.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input int delay);
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic              hit;
        exp_t              e;
        int                exp_lat;
        int                exp_dr;
        int                exp_tr;
        int                lat;
        idx = addr[IDX_W-1:0];
        tag = addr[ADDR_W-1:IDX_W];
        hit = valid_m[idx] && (tag_m[idx] == tag);
        e.is_read = !we;
        e.hit     = hit;
        e.rdata   = '0;
        exp_dr = 0;
        exp_tr = 0;
        if (hit) exp_hits++; else exp_misses++;
        exp_mem_addr  = addr;
        exp_mem_we    = we;
        exp_mem_wdata = wdata;
        if (!we) begin
            if (hit) begin
                e.rdata = data_m[idx];
                exp_lat = 3;
            end else begin
                e.rdata     = mem_value(addr);
                valid_m[idx] = 1'b1;
                tag_m[idx]   = tag;
                data_m[idx]  = e.rdata;
                exp_lat = 5 + delay;
                exp_dr  = 1;
                exp_tr  = 1;
            end
        end else begin
            mem_model[int'(addr)] = wdata;
            if (hit) begin
                data_m[idx] = wdata;
                exp_dr = 1;
            end
            exp_lat = 4 + delay;
        end
        sb.push_back(e);
        ack_delay   = delay;
        dr_we_cnt   = 0;
        tr_we_cnt   = 0;
        mem_req_cnt = 0;
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clock);
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_ready && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if (!cpu_ready) checkOutput("ready_timeout", 32'(cpu_ready), 32'd1);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        @(negedge clock);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("mem_req_seen", 32'(mem_req_cnt > 0), 32'(we || !hit));
        checkOutput("dr_we_cnt", 32'(dr_we_cnt), 32'(exp_dr));
        checkOutput("tr_we_cnt", 32'(tr_we_cnt), 32'(exp_tr));
        if (exp_dr == 1) checkOutput("dr_din", 32'(last_dr_din), 32'(we ? wdata : e.rdata));
        if (exp_tr == 1) begin
            checkOutput("tr_din", 32'(last_tr_din), 32'(tag));
            checkOutput("tr_addr", 32'(last_tr_addr), 32'(idx));
        end
    endtask

    // Safety net in case the DUT stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        logic [ADDR_W-1:0] pick [6];
        int waited;
        pick = '{17'h00005, 17'h00015, 17'h0000D, 17'h00025, 17'h00002, 17'h00012};
        for (int i = 0; i < 8; i++) begin
            valid_m[i] = 1'b0;
            tag_m[i]   = '0;
            data_m[i]  = '0;
        end
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        #12;
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_tr_we", 32'(tr_we), 32'd0);
        checkOutput("rst_dr_we", 32'(dr_we), 32'd0);
        checkOutput("rst_hit_count", 32'(hit_count), 32'd0);
        checkOutput("rst_miss_count", 32'(miss_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] basic miss, hit, tag conflict");
        applyStimulus(1'b0, 17'h00005, 8'h00, 0);
        applyStimulus(1'b0, 17'h00005, 8'h00, 0);
        applyStimulus(1'b0, 17'h00015, 8'h00, 2);
        applyStimulus(1'b0, 17'h00005, 8'h00, 1);

        $display("[TB] write hit, write miss");
        applyStimulus(1'b0, 17'h00015, 8'h00, 0);
        applyStimulus(1'b1, 17'h00015, 8'h3C, 1);
        applyStimulus(1'b0, 17'h00015, 8'h00, 0);
        applyStimulus(1'b1, 17'h00007, 8'h5A, 3);
        applyStimulus(1'b0, 17'h00007, 8'h00, 0);

        $display("[TB] long memory wait");
        applyStimulus(1'b0, 17'h00009, 8'h00, 10);

        $display("[TB] mixed accesses");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), pick[$urandom_range(0, 5)],
                          8'($urandom), $urandom_range(0, 3));
        end

`ifdef CACHE_STATS_EN
        checkOutput("hit_count", 32'(hit_count), 32'(exp_hits));
        checkOutput("miss_count", 32'(miss_count), 32'(exp_misses));
`else
        checkOutput("hit_count_off", 32'(hit_count), 32'd0);
        checkOutput("miss_count_off", 32'(miss_count), 32'd0);
`endif

        $display("[TB] reset during memory read");
        ack_delay = 50;
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 17'h0000D ^ 17'h00100;
        @(negedge clock);
        cpu_req = 1'b0;
        waited = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("abort_mem_req_up", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_tr_we", 32'(tr_we), 32'd0);
        checkOutput("abort_dr_we", 32'(dr_we), 32'd0);
        checkOutput("abort_hit_count", 32'(hit_count), 32'd0);
        checkOutput("abort_miss_count", 32'(miss_count), 32'd0);
        for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b0, 17'h00005, 8'h00, 0);
        applyStimulus(1'b0, 17'h00005, 8'h00, 0);

`ifdef CACHE_STATS_EN
        checkOutput("hit_count_post", 32'(hit_count), 32'(exp_hits));
        checkOutput("miss_count_post", 32'(miss_count), 32'(exp_misses));
`endif
        checkOutput("sb_left", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller.
- Sequences the 8-entry synchronous-read tag RAM and a matching data RAM, both sharing one index address, to service single CPU requests.
- Issues fills and write-throughs to backing memory over a req/ack handshake.
- Valid bits are held in the controller so reset invalidates the cache without touching RAM contents.

Parameters:
IDX_W, 3, index width; tag/data RAM depth = 1<<IDX_W
TAG_W, 14, tag width; equals tag RAM data width
DATA_W, 8, cached word width
ADDR_W, TAG_W+IDX_W (localparam), CPU/memory address width; tag = addr[ADDR_W-1:IDX_W], index = addr[IDX_W-1:0]

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  hit flag, valid while cpu_ready=1
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1 on reads
busy  out  1  high in every state except IDLE
tr_addr  out  IDX_W  tag RAM address; data RAM uses the same address
tr_din  out  TAG_W  tag RAM write data
tr_we  out  1  tag RAM write enable
tr_dout  in  TAG_W  tag RAM read data, one cycle after address
dr_din  out  DATA_W  data RAM write data
dr_we  out  1  data RAM write enable
dr_dout  in  DATA_W  data RAM read data, one cycle after address
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory acknowledge, one cycle
hit_count  out  16  hit counter (optional feature)
miss_count  out  16  miss counter (optional feature)

Behaviour:
- Reset: state IDLE; valid[] all 0; cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, tr_we, dr_we, busy, counters all 0; request registers cleared. A reset mid-operation aborts the access immediately, drops mem_req and performs no RAM write.
- tr_addr always equals the latched index register. mem_addr and mem_wdata come from the latched request.
- FSM states and transitions:
  - IDLE: on cpu_req, latch addr, we and wdata, then go to LOOKUP.
  - LOOKUP: the RAMs latch the address on this edge; go to COMPARE.
  - COMPARE: hit = valid[idx] & (tr_dout == tag_q); register hit_q and capture dr_dout into the rdata register.
    - Read hit: go to DONE.
    - Read miss: go to MEM_RD.
    - Write: dr_we = hit, dr_din = wdata_q in this cycle, then go to MEM_WR.
  - MEM_RD: mem_req=1, mem_we=0. On the edge where mem_ack=1, capture mem_rdata and go to FILL.
  - FILL: tr_we=1, tr_din=tag_q, dr_we=1, dr_din=captured data; valid[idx] is set to 1; go to DONE.
  - MEM_WR: mem_req=1, mem_we=1. On mem_ack, go to DONE.
  - DONE: cpu_ready=1, cpu_hit=hit_q, cpu_rdata=rdata register; return to IDLE.
- Latency:
  - Read hit: cpu_ready asserts 3 cycles after cpu_req is sampled.
  - Read miss: 5 cycles plus memory wait cycles.
  - Write: 4 cycles plus memory wait cycles.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled.
  - mem_ack may arrive in the first MEM cycle.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
  - cpu_req while busy is ignored and not queued.
- Tag conflict (same index, different tag) is a miss; the fill overwrites the tag and data.
- A write miss allocates nothing and leaves valid[] unchanged.

Optional Feature:
- CACHE_STATS_EN defined: hit_count and miss_count increment by 1 on the COMPARE cycle (reads and writes) and saturate at 16'hFFFF. Reset clears them.
- CACHE_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- After reset, read 0x00005 -> miss; mem_req with mem_addr=0x00005; ack with mem_rdata=0xA5 -> tr_we with tr_din=0x0000 at index 5, cpu_ready, cpu_hit=0, cpu_rdata=0xA5.
- Repeat read 0x00005 -> cpu_ready 3 cycles after request, cpu_hit=1, cpu_rdata=0xA5, mem_req never asserted.
- Read 0x00015 (tag 0x0002, index 5) -> miss; tag replaced with 0x0002; then read 0x00005 -> miss again.
- Write 0x00015 data 0x3C on a hit -> dr_we=1 with 0x3C in COMPARE; mem_req/mem_we with mem_wdata=0x3C; following read -> hit, 0x3C. Write miss to 0x00007 -> valid[7] remains 0.
- Hold mem_ack low for 10 cycles, then pulse; pulse reset_n low during MEM_RD -> mem_req drops asynchronously, FSM in IDLE, next read of index 5 misses.
- With CACHE_STATS_EN defined: 2 hits and 3 misses -> hit_count=2, miss_count=3. Without it -> both read 0.
